// File: rtl/mem_copy_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_copy_master                                            |
// | Description : Bus-initiator engine that fills or copies word blocks on   |
// |               the native select/ready SRAM interface.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_copy_master #(
    parameter int ADDRWIDTH = 32,
    parameter int LENWIDTH  = 12,
    parameter int TIMEOUT   = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDRWIDTH-1:0] src_addr,
    input  logic [ADDRWIDTH-1:0] dst_addr,
    input  logic [LENWIDTH-1:0]  length,
    input  logic [31:0]          pattern,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LENWIDTH-1:0]  words_done,
    output logic                 mem_select,
    output logic [3:0]           mem_wstrb,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata
);

    localparam int                   c_TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                   c_TO_EN = (TIMEOUT > 0);
    localparam logic [c_TW-1:0]      c_TLAST = (TIMEOUT > 0) ? c_TW'(TIMEOUT - 1) : '0;
    localparam logic [ADDRWIDTH-1:0] c_WORD  = ADDRWIDTH'(4);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_READ  = 3'd1;
    localparam logic [2:0] c_S_RGAP  = 3'd2;
    localparam logic [2:0] c_S_WRITE = 3'd3;
    localparam logic [2:0] c_S_WGAP  = 3'd4;
    localparam logic [2:0] c_S_DONE  = 3'd5;

    logic [2:0]           r_state,      w_state;
    logic                 r_busy,       w_busy;
    logic                 r_done,       w_done;
    logic                 r_error,      w_error;
    logic [LENWIDTH-1:0]  r_words_done, w_words_done;
    logic                 r_select,     w_select;
    logic [3:0]           r_wstrb,      w_wstrb;
    logic [ADDRWIDTH-1:0] r_addr,       w_addr;
    logic [31:0]          r_wdata,      w_wdata;
    logic                 r_mode,       w_mode;
    logic [LENWIDTH-1:0]  r_len,        w_len;
    logic [31:0]          r_pattern,    w_pattern;
    logic [ADDRWIDTH-1:0] r_src,        w_src;
    logic [ADDRWIDTH-1:0] r_dst,        w_dst;
    logic [c_TW-1:0]      r_tcnt,       w_tcnt;

    logic [ADDRWIDTH-1:0] w_src_al;
    logic [ADDRWIDTH-1:0] w_dst_al;

    assign w_src_al = {src_addr[ADDRWIDTH-1:2], 2'b00};
    assign w_dst_al = {dst_addr[ADDRWIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words_done <= '0;
            r_select     <= 1'b0;
            r_wstrb      <= 4'h0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mode       <= 1'b0;
            r_len        <= '0;
            r_pattern    <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_tcnt       <= '0;
        end else begin
            r_state      <= w_state;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_error      <= w_error;
            r_words_done <= w_words_done;
            r_select     <= w_select;
            r_wstrb      <= w_wstrb;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_mode       <= w_mode;
            r_len        <= w_len;
            r_pattern    <= w_pattern;
            r_src        <= w_src;
            r_dst        <= w_dst;
            r_tcnt       <= w_tcnt;
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        w_state      = r_state;
        w_error      = r_error;
        w_words_done = r_words_done;
        w_select     = r_select;
        w_wstrb      = r_wstrb;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_mode       = r_mode;
        w_len        = r_len;
        w_pattern    = r_pattern;
        w_src        = r_src;
        w_dst        = r_dst;
        w_tcnt       = r_tcnt;

        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_error      = 1'b0;
                    w_words_done = '0;
                    w_mode       = mode;
                    w_len        = length;
                    w_pattern    = pattern;
                    w_src        = w_src_al;
                    w_dst        = w_dst_al;
                    w_tcnt       = '0;
                    if (length == '0) begin
                        w_state = c_S_DONE;
                    end else if (mode) begin
                        w_state  = c_S_READ;
                        w_select = 1'b1;
                        w_wstrb  = 4'h0;
                        w_addr   = w_src_al;
                    end else begin
                        w_state  = c_S_WRITE;
                        w_select = 1'b1;
                        w_wstrb  = 4'hF;
                        w_addr   = w_dst_al;
                        w_wdata  = pattern;
                    end
                end
            end
            c_S_READ, c_S_WRITE: begin
                if (mem_ready) begin
                    w_select = 1'b0;
                    if (r_state == c_S_READ) begin
                        w_wdata = mem_rdata;
                        w_state = c_S_RGAP;
                    end else begin
                        w_words_done = r_words_done + 1'b1;
                        w_src        = r_src + c_WORD;
                        w_dst        = r_dst + c_WORD;
                        w_state      = c_S_WGAP;
                    end
                end else if (c_TO_EN && (r_tcnt == c_TLAST)) begin
                    w_select = 1'b0;
                    w_error  = 1'b1;
                    w_state  = c_S_DONE;
                end else begin
                    w_tcnt = r_tcnt + 1'b1;
                end
            end
            c_S_RGAP: begin
                w_state  = c_S_WRITE;
                w_select = 1'b1;
                w_wstrb  = 4'hF;
                w_addr   = r_dst;
                w_tcnt   = '0;
            end
            c_S_WGAP: begin
                w_tcnt = '0;
                if (r_words_done == r_len) begin
                    w_state = c_S_DONE;
                end else if (r_mode) begin
                    w_state  = c_S_READ;
                    w_select = 1'b1;
                    w_wstrb  = 4'h0;
                    w_addr   = r_src;
                end else begin
                    w_state  = c_S_WRITE;
                    w_select = 1'b1;
                    w_wstrb  = 4'hF;
                    w_addr   = r_dst;
                    w_wdata  = r_pattern;
                end
            end
            c_S_DONE: begin
                w_state = c_S_IDLE;
            end
            default: begin
                w_state  = c_S_IDLE;
                w_select = 1'b0;
            end
        endcase

        w_done = (w_state == c_S_DONE);
        w_busy = (w_state == c_S_READ) || (w_state == c_S_RGAP) ||
                 (w_state == c_S_WRITE) || (w_state == c_S_WGAP);
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign words_done = r_words_done;
    assign mem_select = r_select;
    assign mem_wstrb  = r_wstrb;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_copy_master                                         |
// | Description : Scoreboard bench for mem_copy_master with an SRAM model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_copy_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [11:0] length;
    logic [31:0] pattern;
    logic        busy;
    logic        done;
    logic        error;
    logic [11:0] words_done;
    logic        mem_select;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        int          cyc;
        logic [11:0] words;
        logic        err;
    } done_t;

    bus_t        exp_bus[$];
    done_t       exp_done[$];
    logic [31:0] sram [0:1023];
    logic        stall;
    int          cyc;
    int          sel_cnt;
    int          checks;
    int          errors;

    mem_copy_master #(
        .ADDRWIDTH(32),
        .LENWIDTH (12),
        .TIMEOUT  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .pattern   (pattern),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .words_done(words_done),
        .mem_select(mem_select),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder registers ready from select, so ready lags select by one cycle.
    always @(posedge clk) begin
        mem_ready <= mem_select && !stall;
        mem_rdata <= mem_select ? sram[mem_addr[11:2]] : 32'h0;
        if (mem_select && mem_ready && mem_wstrb == 4'hF)
            sram[mem_addr[11:2]] <= mem_wdata;
    end

    always @(negedge clk) if (mem_select) sel_cnt <= sel_cnt + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a bus beat or pulses done.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_select && mem_ready) begin
                if (exp_bus.size() == 0) begin
                    check("unexpected_beat", {mem_addr, mem_wdata}, 64'h0);
                end else begin
                    bus_t b;
                    b = exp_bus.pop_front();
                    check("beat_addr", {32'h0, mem_addr}, {32'h0, b.addr});
                    check("beat_wstrb", {60'h0, mem_wstrb},
                          {60'h0, b.wstrb});
                    check("beat_data",
                          {32'h0, (mem_wstrb == 4'hF) ? mem_wdata : mem_rdata},
                          {32'h0, b.data});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                    check("done_words", {52'h0, words_done}, {52'h0, d.words});
                    check("done_error", {63'h0, error}, {63'h0, d.err});
                end
            end
        end
    end

    task automatic start_op(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [11:0] len, input logic [31:0] pat, output int t0);
        @(posedge clk); #1;
        mode = m; src_addr = s; dst_addr = d; length = len; pattern = pat;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~m; src_addr = 32'hDEAD_BEE0; dst_addr = 32'hBAD0_0000;
        length = 12'd9; pattern = 32'h5555_5555;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < limit);
        if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        bus_t b;
        b.addr = a; b.wstrb = w; b.data = d;
        exp_bus.push_back(b);
    endtask

    task automatic push_done(input int c, input logic [11:0] w, input logic e);
        done_t d;
        d.cyc = c; d.words = w; d.err = e;
        exp_done.push_back(d);
    endtask

    initial begin
        int t0;
        int s0;
        checks = 0; errors = 0; cyc = 0; sel_cnt = 0; stall = 1'b0;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; pattern = '0;
        for (int i = 0; i < 1024; i++) sram[i] = 32'h0;

        @(negedge clk);
        check("reset_outputs",
              {43'h0, busy, done, error, words_done, mem_select, mem_wstrb},
              64'h0);
        check("reset_addr_data", {mem_addr, mem_wdata}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: fill 4 words at 0x100; a start during DONE must be ignored
        start_op(1'b0, 32'h0, 32'h100, 12'd4, 32'hA5A5_0001, t0);
        for (int i = 0; i < 4; i++) push_beat(32'h100 + 32'(4 * i), 4'hF, 32'hA5A5_0001);
        push_done(t0 + 13, 12'd4, 1'b0);
        wait_done("fill4", 40);
        start = 1'b1; mode = 1'b0; length = 12'd5; dst_addr = 32'h180;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_in_done_ignored", {62'h0, busy, mem_select}, 64'h0);
        for (int i = 0; i < 4; i++)
            check("fill4_mem", {32'h0, sram[64 + i]}, 64'hA5A5_0001);

        // 2: copy 3 words 0x000 -> 0x200
        sram[0] = 32'h11; sram[1] = 32'h22; sram[2] = 32'h33;
        start_op(1'b1, 32'h0, 32'h200, 12'd3, 32'hFFFF_FFFF, t0);
        for (int i = 0; i < 3; i++) begin
            push_beat(32'(4 * i), 4'h0, 32'h11 * 32'(i + 1));
            push_beat(32'h200 + 32'(4 * i), 4'hF, 32'h11 * 32'(i + 1));
        end
        push_done(t0 + 19, 12'd3, 1'b0);
        wait_done("copy3", 60);
        for (int i = 0; i < 3; i++)
            check("copy3_mem", {32'h0, sram[128 + i]}, {32'h0, 32'h11 * 32'(i + 1)});

        // 3: zero length completes immediately without touching the bus
        s0 = sel_cnt;
        start_op(1'b0, 32'h0, 32'h300, 12'd0, 32'h1234_5678, t0);
        push_done(t0 + 1, 12'd0, 1'b0);
        wait_done("len0", 10);
        #1;
        check("len0_no_select", 64'(sel_cnt - s0), 64'd0);

        // 4: stalled responder hits the 8-cycle timeout; next start clears error
        stall = 1'b1;
        s0 = sel_cnt;
        start_op(1'b0, 32'h0, 32'h300, 12'd2, 32'hCAFE_0000, t0);
        push_done(t0 + 9, 12'd0, 1'b1);
        wait_done("timeout", 30);
        repeat (3) @(negedge clk);
        check("timeout_select_cycles", 64'(sel_cnt - s0), 64'd8);
        check("timeout_error_held", {62'h0, error, mem_select}, 64'd2);
        stall = 1'b0;
        start_op(1'b0, 32'h0, 32'h304, 12'd1, 32'hCAFE_0001, t0);
        push_beat(32'h304, 4'hF, 32'hCAFE_0001);
        push_done(t0 + 4, 12'd1, 1'b0);
        @(negedge clk);
        check("error_cleared_by_start", {62'h0, error, busy}, 64'd1);
        wait_done("after_timeout", 20);

        // 5: asynchronous reset while a copy read is on the bus
        start_op(1'b1, 32'h0, 32'h200, 12'd3, 32'h0, t0);
        #2;
        check("select_before_reset", {63'h0, mem_select}, 64'd1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {61'h0, mem_select, busy, done}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {49'h0, busy, error, words_done, mem_select}, 64'h0);
        start_op(1'b0, 32'h0, 32'h400, 12'd2, 32'h0BAD_F00D, t0);
        push_beat(32'h400, 4'hF, 32'h0BAD_F00D);
        push_beat(32'h404, 4'hF, 32'h0BAD_F00D);
        push_done(t0 + 7, 12'd2, 1'b0);
        wait_done("post_reset_fill", 30);

        // 6: destination wraps past the top of the address space; start while busy ignored
        start_op(1'b0, 32'h0, 32'hFFFF_FFF8, 12'd3, 32'h0F0F_F0F0, t0);
        push_beat(32'hFFFF_FFF8, 4'hF, 32'h0F0F_F0F0);
        push_beat(32'hFFFF_FFFC, 4'hF, 32'h0F0F_F0F0);
        push_beat(32'h0000_0000, 4'hF, 32'h0F0F_F0F0);
        push_done(t0 + 10, 12'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b1; length = 12'd7; src_addr = 32'h40; dst_addr = 32'h80;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("wrap_fill", 40);
        repeat (4) @(negedge clk);
        check("wrap_idle_after", {62'h0, busy, mem_select}, 64'h0);
        check("wrap_mem_zero", {32'h0, sram[0]}, 64'h0F0F_F0F0);

        check("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
        check("done_queue_empty", 64'(exp_done.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus-initiator engine for the native valid/ready memory interface used by the on-chip SRAM: select, wstrb, addr, data in/out, ready.
- Performs word-wise block fill (constant pattern) or block copy (src to dst) without CPU involvement.
- Sits beside the CPU on the memory bus; the bus arbiter grants it the SRAM port while busy.
- Control comes from a register-block front end (start/mode/addresses/length); status is returned as busy/done/error.

Parameters:
ADDRWIDTH, 32, width of byte addresses on the bus and config ports
LENWIDTH, 12, width of the word-count field
TIMEOUT, 256, max cycles select may stay high without ready; 0 disables timeout

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
mode  input  1  0 = fill, 1 = copy
src_addr  input  ADDRWIDTH  copy source byte address; bits [1:0] ignored
dst_addr  input  ADDRWIDTH  destination byte address; bits [1:0] ignored
length  input  LENWIDTH  number of 32-bit words
pattern  input  32  fill word
busy  output  1  high whenever FSM not in IDLE/DONE
done  output  1  one-cycle completion pulse
error  output  1  timeout flag; held until next accepted start
words_done  output  LENWIDTH  words written so far
mem_select  output  1  bus request
mem_wstrb  output  4  0000 read, 1111 write
mem_addr  output  ADDRWIDTH  word-aligned byte address ([1:0]=00)
mem_wdata  output  32  write data
mem_ready  input  1  responder completion
mem_rdata  input  32  read data, valid when mem_ready high

Behaviour:
- Reset (async, any state): all outputs 0, FSM to IDLE, counters 0; mem_select drops immediately, and any in-flight transfer is abandoned.
- All outputs are registered. start is latched together with mode/src/dst/length/pattern; later input changes have no effect.
- States: IDLE, READ, RGAP, WRITE, WGAP, DONE.
- IDLE + start: clear error and words_done.
  - length==0: go to DONE.
  - mode=1: go to READ with mem_addr=src.
  - mode=0: go to WRITE with mem_addr=dst and mem_wdata=pattern.
- start outside IDLE is ignored.
- READ: mem_select=1, wstrb=0000.
  - On mem_ready=1: capture mem_rdata into mem_wdata, deassert select, go to RGAP.
- RGAP: select=0 for exactly one cycle, then WRITE with mem_addr=dst pointer.
- WRITE: mem_select=1, wstrb=1111.
  - On mem_ready=1: deassert select, increment words_done, advance both pointers by 4, go to WGAP.
- WGAP: select=0 for one cycle.
  - If words_done==length: go to DONE.
  - Else: READ (copy) or WRITE (fill, mem_wdata=pattern).
- The mandatory gap cycle exists because the responder registers ready from select: its ready stays high one cycle after select falls. mem_ready is ignored whenever mem_select=0.
- mem_addr, wstrb and wdata are stable for the entire time select is high.
- Pointer wrap: addresses increment modulo 2^ADDRWIDTH with no error.
- Timeout: a cycle counter runs while select=1 and ready=0.
  - Reaching TIMEOUT (nonzero): select drops, error=1, go to DONE. words_done holds the count completed so far.
  - The counter clears at every new request.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start arriving in DONE is ignored.
- Throughput against a zero-wait responder (ready 1 cycle after select):
  - fill: 3 cycles/word
  - copy: 6 cycles/word
- Overlapping src/dst ranges are copied in ascending order, with no hazard protection.

Test Plan:
1. Fill, dst=0x100, length=4, pattern=0xA5A5_0001, zero-wait SRAM model -> words 0x100..0x10C read back as 0xA5A5_0001; done pulses exactly 13 cycles after the start edge; words_done=4.
2. Copy, src=0x000 preloaded 0x11,0x22,0x33, dst=0x200, length=3 -> 0x200..0x208 hold 0x11,0x22,0x33; every read has wstrb=0000; done after 18+1 cycles.
3. length=0 with start -> done pulses next cycle; mem_select never asserted; error=0.
4. Responder holding ready low forever, TIMEOUT=8, fill length=2 -> select high exactly 8 cycles then low; error=1; done pulse; words_done=0. A following start clears error.
5. Reset asserted mid-copy while select=1 -> select, busy and done go 0 asynchronously; FSM IDLE; a new fill afterwards completes normally.
6. dst=0xFFFF_FFF8, fill length=3 -> writes go to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; no error. A start pulse issued while busy is ignored.
